rift2_wb_arbiter: RTL and testbench
===================================

Name: rift2_wb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter inside the rift2 user area.
- Shares one downstream Wishbone slave port between two requesters:
  - the management SoC slave path (master 0);
  - the rift2 core data port (master 1).
- Downstream slave is the shared on-chip SRAM / config register bank.
- Round-robin grant, bus lock for the whole cyc tenure, optional stall-timeout watchdog.

Parameters:
AW, 32, address width of all ports
DW, 32, data width; SEL width = DW/8
TIMEOUT_CYC, 255, stall cycles before watchdog fires (used only with optional feature); counter width = clog2(TIMEOUT_CYC+1)

Ports:
wb_clk_i  in  1  single clock
rst_n  in  1  asynchronous active-low reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (mgmt) request
m0_sel_i  in  DW/8  master 0 byte select
m0_adr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_ack_o, m0_err_o  out  1 each  master 0 responses
m0_dat_o  out  DW  master 0 read data
m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i  in  (as m0)  master 1 (core) request
m1_ack_o, m1_err_o, m1_dat_o  out  (as m0)  master 1 responses
s_cyc_o, s_stb_o, s_we_o  out  1 each  downstream request
s_sel_o  out  DW/8  downstream byte select
s_adr_o  out  AW  downstream address
s_dat_o  out  DW  downstream write data
s_ack_i  in  1  downstream ack
s_dat_i  in  DW  downstream read data
grant_o  out  2  one-hot current owner; 00 = idle
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_n low, async):
  - state IDLE, grant_o = 00, priority pointer = m0;
  - timeout_o = 0, all s_* outputs = 0, all m*_ack/err/dat = 0;
  - any in-flight cycle is abandoned.
- FSM states: IDLE, OWN0, OWN1. State and grant are registered.
- IDLE:
  - if exactly one mX_cyc_i is high, go to OWNX at the next edge;
  - if both are high, pick the master the pointer favours;
  - the pointer favours the master NOT granted last (m0 after reset).
- OWNX:
  - s_* outputs are a combinational mux of master X's inputs;
  - s_cyc_o = mX_cyc_i, s_stb_o = mX_stb_i;
  - s_ack_i routes to mX_ack_o and s_dat_i routes to mX_dat_o;
  - the non-owner sees ack = 0, err = 0, dat = 0 (stalls).
- Lock: ownership holds while mX_cyc_i stays high, across multiple stb/ack beats (block transfers).
- Release:
  - when mX_cyc_i is low at an edge, return to IDLE and set the pointer to the other master;
  - at least one IDLE cycle always separates two tenures, so no back-to-back grant switch occurs.
- Latency: cyc asserted at edge N gives grant_o and s_cyc_o high in cycle N+1; ack passes with zero added latency.
- Simultaneous release and new request: the released master's drop takes effect first; the other master is granted after the IDLE cycle.
- Downstream ack while s_stb_o is low is ignored and not forwarded.
- Bus errors: m*_err_o is driven only by the watchdog; the downstream slave has no err line.

Optional Feature:
- Macro: RIFT2_WB_ARB_TIMEOUT_EN.
- Enabled:
  - a counter runs while the owner has s_cyc_o & s_stb_o high and s_ack_i low; it clears on ack or release;
  - when the count reaches TIMEOUT_CYC, drive a one-cycle mX_err_o = 1 (ack stays 0) to the owner;
  - set timeout_o (sticky until reset) and force return to IDLE the next cycle;
  - s_cyc_o drops even if the master still holds cyc;
  - that master must deassert cyc before it can be regranted.
- Disabled: no counter, m*_err_o = 0 and timeout_o = 0 constantly; a stalled slave hangs the bus.

Test Plan:
- Reset, then m0 single read from 0x3000_0010, slave acks 2 cycles later with 0x1234_5678 -> grant_o = 01 one cycle after cyc; m0_dat_o = 0x1234_5678 with m0_ack_o; m1_ack_o = 0.
- m0 and m1 assert cyc in the same cycle after reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then grant_o = 10.
- Repeated simultaneous requests over 4 tenures -> grant order m0, m1, m0, m1.
- m1 holds cyc for a 4-beat write burst while m0 requests -> m0 stalls until m1 releases; all 4 s_ack_i reach m1 only.
- Assert rst_n low mid-burst -> all outputs 0 immediately (async); after release, state IDLE and pointer favours m0.
- With RIFT2_WB_ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, slave never acks -> m0_err_o pulses after 8 stall cycles; timeout_o = 1 and stays 1; s_cyc_o = 0 next cycle. Without the macro -> bus holds, err stays 0.

Source files
------------

// File: rtl/rift2_wb_arbiter.sv
// rift2_wb_arbiter: two-master round-robin Wishbone classic arbiter, bus locked for the whole cyc tenure.
// Define RIFT2_WB_ARB_TIMEOUT_EN to add the stall watchdog (err pulse, sticky timeout_o).
module rift2_wb_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            wb_clk_i,
  input  logic            rst_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t     r_state;
  logic [1:0] r_grant;
  logic       r_ptr;
  logic [1:0] w_req;
  logic       w_pick0, w_ack, w_err, w_rel;
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
  assign s_cyc_o  = r_grant[0] ? m0_cyc_i : r_grant[1] ? m1_cyc_i : 1'b0;
  assign s_stb_o  = r_grant[0] ? m0_stb_i : r_grant[1] ? m1_stb_i : 1'b0;
  assign s_we_o   = r_grant[0] ? m0_we_i  : r_grant[1] ? m1_we_i  : 1'b0;
  assign s_sel_o  = r_grant[0] ? m0_sel_i : r_grant[1] ? m1_sel_i : '0;
  assign s_adr_o  = r_grant[0] ? m0_adr_i : r_grant[1] ? m1_adr_i : '0;
  assign s_dat_o  = r_grant[0] ? m0_dat_i : r_grant[1] ? m1_dat_i : '0;
  // an ack without a strobe is not a beat and is dropped
  assign w_ack    = s_ack_i & s_stb_o & ~w_err;
  assign m0_ack_o = r_grant[0] & w_ack;
  assign m1_ack_o = r_grant[1] & w_ack;
  assign m0_err_o = r_grant[0] & w_err;
  assign m1_err_o = r_grant[1] & w_err;
  assign m0_dat_o = r_grant[0] ? s_dat_i : '0;
  assign m1_dat_o = r_grant[1] ? s_dat_i : '0;
  assign grant_o  = r_grant;
  assign w_rel    = ~s_cyc_o | w_err;
  assign w_pick0  = w_req[0] & (~w_req[1] | ~r_ptr);
`ifdef RIFT2_WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_blk;
  logic          r_timeout;
  assign w_err     = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT_CYC));
  // a master cut off by the watchdog must drop cyc before it may compete again
  assign w_req     = {m1_cyc_i, m0_cyc_i} & ~r_blk;
  assign timeout_o = r_timeout;
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      r_cnt     <= '0;
      r_blk     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= (r_state == IDLE || w_rel || (s_ack_i && s_stb_o)) ? '0 : s_stb_o ? r_cnt + 1'b1 : r_cnt;
      r_blk     <= (r_blk | (w_err ? r_grant : 2'b00)) & {m1_cyc_i, m0_cyc_i};
      r_timeout <= r_timeout | w_err;
    end
`else
  assign w_err     = 1'b0;
  assign w_req     = {m1_cyc_i, m0_cyc_i};
  assign timeout_o = 1'b0;
`endif
  // r_ptr = 1 favours m1; it points away from the master that released last
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_ptr   <= 1'b0;
    end else if (r_state == IDLE) begin
      r_state <= w_pick0 ? OWN0 : w_req[1] ? OWN1 : IDLE;
      r_grant <= w_pick0 ? 2'b01 : w_req[1] ? 2'b10 : 2'b00;
    end else if (w_rel) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_ptr   <= (r_state == OWN0);
    end
endmodule

// File: tb/tb_rift2_wb_arbiter.sv
// tb_rift2_wb_arbiter: directed scenarios plus random traffic checked every cycle against a behavioural model.
module tb_rift2_wb_arbiter;
  localparam int TO = 8;
  logic        clk = 0, rst_n = 1;
  logic        mc[2], ms[2], mw[2];
  logic [3:0]  msel[2];
  logic [31:0] madr[2], mdat[2];
  logic        s_ack;
  logic [31:0] s_dat;
  logic        ack_o[2], err_o[2];
  logic [31:0] dat_o[2];
  logic        s_cyc, s_stb, s_we, timeout;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dato;
  logic [1:0]  grant;
  int          vec = 0, bad = 0;
  rift2_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
    .wb_clk_i(clk), .rst_n(rst_n),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(msel[0]), .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]),
    .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_dat_o(dat_o[0]),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(msel[1]), .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]),
    .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_dat_o(dat_o[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dato),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .grant_o(grant), .timeout_o(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  // model: owner (-1 idle), last released owner, consecutive stall cycles, lockout after watchdog
  int own = -1, last = 1, stall = 0;
  bit tmo = 0;
  bit blk[2] = '{0, 0};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own = -1; last = 1; stall = 0; tmo = 0; blk = '{0, 0};
    end else begin
      bit er, r0, r1;
      int nx;
      er = 0;
`ifdef RIFT2_WB_ARB_TIMEOUT_EN
      er = own >= 0 && stall == TO;
`endif
      nx = own;
      if (own < 0) begin
        r0 = mc[0] && !blk[0];
        r1 = mc[1] && !blk[1];
        nx = (r0 && r1) ? (last == 0 ? 1 : 0) : r0 ? 0 : r1 ? 1 : -1;
      end else if (!mc[own] || er) begin
        last = own;
        nx = -1;
        if (er) begin blk[own] = 1; tmo = 1; end
      end
      stall = (own < 0 || nx < 0 || (ms[own] && s_ack)) ? 0 : ms[own] ? stall + 1 : stall;
      for (int i = 0; i < 2; i++) blk[i] = blk[i] && mc[i];
      own = nx;
    end
  end
  always @(negedge clk) begin
    bit er;
    int k;
    er = 0;
`ifdef RIFT2_WB_ARB_TIMEOUT_EN
    er = own >= 0 && stall == TO;
`endif
    k = own < 0 ? 0 : own;
    chk("grant", grant, own < 0 ? 2'b00 : own == 0 ? 2'b01 : 2'b10);
    chk("s_bus", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dato},
        own < 0 ? 71'h0 : {mc[k], ms[k], mw[k], msel[k], madr[k], mdat[k]});
    for (int i = 0; i < 2; i++)
      chk($sformatf("m%0d_resp", i), {ack_o[i], err_o[i], dat_o[i]},
          {own == i && ms[i] && s_ack && !er, own == i && er, own == i ? s_dat : 32'h0});
    chk("timeout", timeout, tmo);
  end
  task automatic do_reset;
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; ms[i] = 0; mw[i] = 0; msel[i] = 0; madr[i] = 0; mdat[i] = 0;
    end
    s_ack = 0; s_dat = 0;
    step;
    rst_n = 1;
  endtask
  task automatic tenure(input logic [1:0] e, input bit again);
    int n, o;
    n = 0;
    mid;
    while (grant == 2'b00 && n < 10) begin step; mid; n++; end
    chk("t3_order", grant, e);
    o = grant[1] ? 1 : 0;
    step;
    mc[o] = 0; ms[o] = 0;
    if (again) begin step; mc[o] = 1; ms[o] = 1; end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n, k;
    int rem[2];
    bit a[2], e[2];
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; ms[i] = 0; mw[i] = 0; msel[i] = 0; madr[i] = 0; mdat[i] = 0;
    end
    s_ack = 0; s_dat = 0;
    #1 rst_n = 0;
    step;
    rst_n = 1;
    mid;
    chk("rst_out", {grant, s_cyc, ack_o[0], ack_o[1], dat_o[0], dat_o[1], timeout}, 0);
    // single read by m0
    step;
    mc[0] = 1; ms[0] = 1; madr[0] = 32'h3000_0010; msel[0] = 4'hf;
    mid; chk("t1_wait", grant, 2'b00);
    step; mid;
    chk("t1_grant", {grant, s_cyc, s_adr}, {2'b01, 1'b1, 32'h3000_0010});
    step;
    s_ack = 1; s_dat = 32'h1234_5678;
    mid;
    chk("t1_ack", {ack_o[0], dat_o[0], ack_o[1]}, {1'b1, 32'h1234_5678, 1'b0});
    step;
    s_ack = 0; mc[0] = 0; ms[0] = 0;
    mid; step; mid;
    chk("t1_idle", grant, 2'b00);
    // simultaneous request after reset
    do_reset;
    mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
    step; mid; chk("t2_first", grant, 2'b01);
    step; mc[0] = 0; ms[0] = 0;
    mid; step; mid; chk("t2_idle", grant, 2'b00);
    step; mid; chk("t2_second", grant, 2'b10);
    step; mc[1] = 0; ms[1] = 0;
    step;
    // round robin over four tenures
    mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
    for (int t = 0; t < 4; t++) tenure(t % 2 == 0 ? 2'b01 : 2'b10, t < 3);
    mc[0] = 0; ms[0] = 0;
    step; step;
    // m1 write burst locks out m0
    mc[1] = 1; ms[1] = 1; mw[1] = 1; madr[1] = 32'h0000_0100; mdat[1] = 32'hcafe_f00d;
    step;
    mc[0] = 1; ms[0] = 1;
    for (int b = 0; b < 4; b++) begin
      s_ack = 1; s_dat = $urandom;
      mid; chk("t4_beat", {ack_o[1], ack_o[0], grant}, {1'b1, 1'b0, 2'b10});
      step; s_ack = 0;
      mid; chk("t4_hold", {ack_o[0], grant}, {1'b0, 2'b10});
      step;
    end
    mc[1] = 0; ms[1] = 0; mw[1] = 0;
    mid; step; mid; chk("t4_idle", grant, 2'b00);
    step; mid; chk("t4_m0", grant, 2'b01);
    // reset mid-burst; pointer must return to m0
    step; mc[0] = 0; ms[0] = 0;
    step; mc[0] = 1; ms[0] = 1;
    step; mc[1] = 1; ms[1] = 1; s_ack = 1;
    mid; chk("t5_own", {grant, ack_o[0]}, {2'b01, 1'b1});
    #2 rst_n = 0;
    #1 chk("t5_async", {grant, s_cyc, s_stb, ack_o[0], ack_o[1], dat_o[0], s_adr, timeout}, 0);
    step; rst_n = 1; s_ack = 0;
    mid; chk("t5_idle", grant, 2'b00);
    step; mid; chk("t5_ptr", grant, 2'b01);
    step; mc[0] = 0; ms[0] = 0; mc[1] = 0; ms[1] = 0;
    step;
    // slave never acks
    do_reset;
    mc[0] = 1; ms[0] = 1; madr[0] = 32'h3000_0020;
`ifdef RIFT2_WB_ARB_TIMEOUT_EN
    n = 0; k = 0;
    mid;
    while (!err_o[0] && n < 40) begin
      if (grant == 2'b01) k++;
      step; mid; n++;
    end
    chk("t6_stall_cycles", k, TO);
    chk("t6_err_cycle", {err_o[0], ack_o[0], err_o[1]}, 3'b100);
    step; mid;
    chk("t6_after", {s_cyc, grant, timeout}, {1'b0, 2'b00, 1'b1});
    step; mid;
    chk("t6_locked", {grant, err_o[0], timeout}, {2'b00, 1'b0, 1'b1});
    step; mc[0] = 0; ms[0] = 0;
    step; mc[0] = 1; ms[0] = 1;
    step; mid;
    chk("t6_regrant", {grant, timeout}, {2'b01, 1'b1});
`else
    repeat (20) step;
    mid;
    chk("t6_hang", {grant, s_cyc, err_o[0], timeout}, {2'b01, 1'b1, 1'b0, 1'b0});
`endif
    step; mc[0] = 0; ms[0] = 0;
    step;
    // random traffic
    rem = '{0, 0};
    repeat (3000) begin
      mid;
      for (int i = 0; i < 2; i++) begin a[i] = ack_o[i]; e[i] = err_o[i]; end
      step;
      for (int i = 0; i < 2; i++) begin
        if (mc[i]) begin
          if (e[i]) rem[i] = 0;
          else if (a[i]) rem[i]--;
          if (rem[i] == 0) begin mc[i] = 0; ms[i] = 0; end
          else ms[i] = ($urandom_range(3) != 0);
        end else if ($urandom_range(2) == 0) begin
          rem[i] = $urandom_range(4, 1); mc[i] = 1; ms[i] = 1;
        end
        mw[i] = 1'($urandom); msel[i] = 4'($urandom); madr[i] = $urandom; mdat[i] = $urandom;
      end
      s_ack = ($urandom_range(2) == 0); s_dat = $urandom;
    end
    step; mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
